// File: rtl/vga_frame_overlay.sv
// Pixel colour stage: fetches upscaled image pixel, overlays the face box, realigns syncs.
// Latency: 2 pixel_clk cycles from position/sync inputs to colour/sync outputs.
// Backpressure: box_ready low while a box waits in the pending slot for the next frame start.
module vga_frame_overlay #(
    parameter int          WIDTH     = 10,
    parameter int          IMG_W     = 160,
    parameter int          IMG_H     = 120,
    parameter int          SCALE_SH  = 2,
    parameter int          ADDR_W    = 15,
    parameter int          BORDER    = 2,
    parameter logic [11:0] BOX_COLOR = 12'hF00,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  xpos,
    input  logic [WIDTH-1:0]  ypos,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [11:0]       mem_data,
    input  logic              box_valid,
    output logic              box_ready,
    input  logic              box_clear,
    input  logic [WIDTH-1:0]  box_x0,
    input  logic [WIDTH-1:0]  box_y0,
    input  logic [WIDTH-1:0]  box_x1,
    input  logic [WIDTH-1:0]  box_y1,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              hsync_out,
    output logic              vsync_out
);

    // Extra bit on coordinate arithmetic keeps border sums from wrapping at the screen edge.
    localparam logic [WIDTH:0] L_BORDER = (WIDTH+1)'(BORDER);
    localparam logic [WIDTH:0] L_IMG_XS = (WIDTH+1)'(IMG_W << SCALE_SH);
    localparam logic [WIDTH:0] L_IMG_YS = (WIDTH+1)'(IMG_H << SCALE_SH);

    // Stage 1 state
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_in_img, r_on_box, r_de_d1, r_hs_d1, r_vs_d1;
    // Stage 2 state
    logic [11:0]       r_rgb;
    logic              r_hs_d2, r_vs_d2;
    // Box slots
    logic              r_pend_full, r_pend_en, r_box_en;
    logic [WIDTH-1:0]  r_pend_x0, r_pend_y0, r_pend_x1, r_pend_y1;
    logic [WIDTH-1:0]  r_box_x0, r_box_y0, r_box_x1, r_box_y1;

    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH:0]    w_x, w_y;
    logic              w_in_img, w_inside, w_edge, w_on_box;
    logic              w_commit, w_accept;

    assign w_addr = ADDR_W'(32'(ypos >> SCALE_SH) * 32'(IMG_W) + 32'(xpos >> SCALE_SH));

    assign w_x      = {1'b0, xpos};
    assign w_y      = {1'b0, ypos};
    assign w_in_img = (w_x < L_IMG_XS) && (w_y < L_IMG_YS);

    // A degenerate box (x0>x1 or y0>y1) can never satisfy w_inside, so it draws nothing.
    assign w_inside = (xpos >= r_box_x0) && (xpos <= r_box_x1) &&
                      (ypos >= r_box_y0) && (ypos <= r_box_y1);
    assign w_edge   = (w_x < ({1'b0, r_box_x0} + L_BORDER)) ||
                      ((w_x + L_BORDER) > {1'b0, r_box_x1}) ||
                      (w_y < ({1'b0, r_box_y0} + L_BORDER)) ||
                      ((w_y + L_BORDER) > {1'b0, r_box_y1});
    assign w_on_box = r_box_en && w_inside && w_edge;

    // Frame start is the vsync falling edge; the delayed vsync resets to 0 so reset cannot fake one.
    assign w_commit = r_vs_d1 && !vsync_in;
    assign w_accept = box_valid && !r_pend_full;

    // Stage 1: address generation, region/box classification, first sync delay.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_mem_addr <= '0;
            r_in_img   <= 1'b0;
            r_on_box   <= 1'b0;
            r_de_d1    <= 1'b0;
            r_hs_d1    <= 1'b0;
            r_vs_d1    <= 1'b0;
        end else begin
            r_mem_addr <= w_addr;
            r_in_img   <= w_in_img;
            r_on_box   <= w_on_box;
            r_de_d1    <= de_in;
            r_hs_d1    <= hsync_in;
            r_vs_d1    <= vsync_in;
        end
    end

    // Stage 2: colour select (blanking > box > image > background) and second sync delay.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_rgb   <= 12'h000;
            r_hs_d2 <= 1'b0;
            r_vs_d2 <= 1'b0;
        end else begin
            if (!r_de_d1)
                r_rgb <= 12'h000;
            else if (r_on_box)
                r_rgb <= BOX_COLOR;
            else if (r_in_img)
                r_rgb <= mem_data;
            else
                r_rgb <= BG_COLOR;
            r_hs_d2 <= r_hs_d1;
            r_vs_d2 <= r_vs_d1;
        end
    end

    // Box handoff: requests park in the pending slot and only reach the active box at frame start.
    // Commit needs a full slot and accept needs an empty one, so they never coincide.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_pend_full <= 1'b0;
            r_pend_en   <= 1'b0;
            r_pend_x0   <= '0;
            r_pend_y0   <= '0;
            r_pend_x1   <= '0;
            r_pend_y1   <= '0;
            r_box_en    <= 1'b0;
            r_box_x0    <= '0;
            r_box_y0    <= '0;
            r_box_x1    <= '0;
            r_box_y1    <= '0;
        end else if (w_commit && r_pend_full) begin
            r_box_en    <= r_pend_en;
            r_box_x0    <= r_pend_x0;
            r_box_y0    <= r_pend_y0;
            r_box_x1    <= r_pend_x1;
            r_box_y1    <= r_pend_y1;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend_en   <= !box_clear;
            r_pend_x0   <= box_x0;
            r_pend_y0   <= box_y0;
            r_pend_x1   <= box_x1;
            r_pend_y1   <= box_y1;
            r_pend_full <= 1'b1;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign box_ready = !r_pend_full;
    assign vga_r     = r_rgb[11:8];
    assign vga_g     = r_rgb[7:4];
    assign vga_b     = r_rgb[3:0];
    assign hsync_out = r_hs_d2;
    assign vsync_out = r_vs_d2;

endmodule

// File: tb/tb_vga_frame_overlay.sv
// Bench for vga_frame_overlay: directed scenarios plus random traffic.
// Outputs are compared every cycle against a frame-level reference model.
// Literal expectations pin the model on the key scenarios.
module tb_vga_frame_overlay;

    localparam logic [11:0] BOXC = 12'hF00;
    localparam logic [11:0] BGC  = 12'h05A;

    logic        pixel_clk, rst;
    logic [9:0]  xpos, ypos;
    logic        de_in, hsync_in, vsync_in;
    logic [14:0] mem_addr;
    logic [11:0] mem_data;
    logic        box_valid, box_ready, box_clear;
    logic [9:0]  box_x0, box_y0, box_x1, box_y1;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync_out, vsync_out;

    logic [11:0] img [0:32767];
    assign mem_data = img[mem_addr];

    int n_checks = 0;
    int n_err    = 0;

    vga_frame_overlay #(.BG_COLOR(BGC)) dut (
        .pixel_clk(pixel_clk), .rst(rst),
        .xpos(xpos), .ypos(ypos), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .box_valid(box_valid), .box_ready(box_ready), .box_clear(box_clear),
        .box_x0(box_x0), .box_y0(box_y0), .box_x1(box_x1), .box_y1(box_y1),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   act_en, act_x0, act_y0, act_x1, act_y1;
    int   pend_full, pend_en, pend_x0, pend_y0, pend_x1, pend_y1;
    logic [11:0] m_pipe_rgb, m_out_rgb;
    logic m_pipe_hs, m_pipe_vs, m_out_hs, m_out_vs, m_ready, m_prev_vs;
    logic [14:0] m_addr;
    bit   m_valid = 0;

    function automatic bit model_on_box(input int x, input int y);
        if (act_en == 0) return 1'b0;
        if (x < act_x0 || x > act_x1 || y < act_y0 || y > act_y1) return 1'b0;
        return (x < act_x0 + 2) || (x + 2 > act_x1) || (y < act_y0 + 2) || (y + 2 > act_y1);
    endfunction

    always @(posedge pixel_clk) begin : model
        int x, y, a;
        logic [11:0] c;
        if (rst) begin
            m_pipe_rgb = 12'h000; m_pipe_hs = 1'b0; m_pipe_vs = 1'b0;
            m_out_rgb  = 12'h000; m_out_hs  = 1'b0; m_out_vs  = 1'b0;
            m_addr = 15'd0; m_prev_vs = 1'b0; m_ready = 1'b1;
            act_en = 0; pend_full = 0;
        end else begin
            m_out_rgb = m_pipe_rgb; m_out_hs = m_pipe_hs; m_out_vs = m_pipe_vs;
            x = int'(xpos);
            y = int'(ypos);
            a = ((y / 4) * 160 + x / 4) % 32768;
            m_addr = 15'(a);
            if (!de_in)                   c = 12'h000;
            else if (model_on_box(x, y))  c = BOXC;
            else if (x < 640 && y < 480)  c = img[a];
            else                          c = BGC;
            m_pipe_rgb = c; m_pipe_hs = hsync_in; m_pipe_vs = vsync_in;
            if (m_prev_vs && !vsync_in && pend_full != 0) begin
                act_en = pend_en; act_x0 = pend_x0; act_y0 = pend_y0;
                act_x1 = pend_x1; act_y1 = pend_y1;
                pend_full = 0;
            end else if (box_valid && pend_full == 0) begin
                pend_en = box_clear ? 0 : 1;
                pend_x0 = int'(box_x0); pend_y0 = int'(box_y0);
                pend_x1 = int'(box_x1); pend_y1 = int'(box_y1);
                pend_full = 1;
            end
            m_prev_vs = vsync_in;
            m_ready = (pend_full == 0);
        end
        m_valid = 1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge pixel_clk) begin
        if (m_valid) begin
            chk("rgb",       {vga_r, vga_g, vga_b}, m_out_rgb);
            chk("hsync_out", hsync_out, m_out_hs);
            chk("vsync_out", vsync_out, m_out_vs);
            chk("mem_addr",  mem_addr,  m_addr);
            chk("box_ready", box_ready, m_ready);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge pixel_clk);
    endtask

    task automatic pix(input int x, input int y, input logic [11:0] exp, input string name);
        xpos = 10'(x); ypos = 10'(y); de_in = 1'b1;
        step(); step();
        chk(name, {vga_r, vga_g, vga_b}, exp);
    endtask

    task automatic load_box(input int x0, input int y0, input int x1, input int y1, input logic clr);
        box_x0 = 10'(x0); box_y0 = 10'(y0); box_x1 = 10'(x1); box_y1 = 10'(y1);
        box_clear = clr; box_valid = 1'b1;
        step();
        box_valid = 1'b0; box_clear = 1'b0;
    endtask

    task automatic frame_start();
        vsync_in = 1'b0; step();
        vsync_in = 1'b1; step();
    endtask

    initial begin
        logic [11:0] v;
        for (int i = 0; i < 32768; i++) begin
            v = 12'($urandom);
            if (v == BOXC) v = 12'h123;
            img[i] = v;
        end
        img[162] = 12'h3A5;

        rst = 1'b1; xpos = 10'd8; ypos = 10'd4; de_in = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1; box_valid = 1'b0; box_clear = 1'b0;
        box_x0 = '0; box_y0 = '0; box_x1 = '0; box_y1 = '0;
        step(); step(); step();
        chk("reset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("reset_hsync", hsync_out, 1'b0);
        chk("reset_vsync", vsync_out, 1'b0);
        chk("reset_addr", mem_addr, 15'd0);
        chk("reset_ready", box_ready, 1'b1);

        // Address and latency
        rst = 1'b0;
        step();
        chk("addr_8_4", mem_addr, 15'd162);
        hsync_in = 1'b0; de_in = 1'b0;
        step();
        chk("latency_rgb", {vga_r, vga_g, vga_b}, 12'h3A5);
        chk("latency_hs_hi", hsync_out, 1'b1);
        hsync_in = 1'b1;
        step();
        chk("hs_pulse", hsync_out, 1'b0);
        chk("blank_rgb", {vga_r, vga_g, vga_b}, 12'h000);

        // Region and blanking
        pix(640, 10, BGC, "bg_x640");
        pix(20, 500, BGC, "bg_y500");
        de_in = 1'b0; xpos = 10'd100; ypos = 10'd100;
        step(); step();
        chk("de_low", {vga_r, vga_g, vga_b}, 12'h000);

        // Box commit timing
        load_box(100, 50, 199, 149, 1'b0);
        chk("ready_after_accept", box_ready, 1'b0);
        pix(101, 80, img[3225], "no_box_yet");
        frame_start();
        chk("ready_after_commit", box_ready, 1'b1);
        pix(101, 80,  BOXC,      "box_101_80");
        pix(102, 80,  img[3225], "box_102_80");
        pix(198, 80,  BOXC,      "box_198_80");
        pix(150, 148, BOXC,      "box_150_148");

        // Screen-edge box, no wrap
        load_box(630, 470, 639, 479, 1'b0);
        frame_start();
        pix(638, 475, BOXC,       "edge_638");
        pix(639, 479, BOXC,       "edge_639_479");
        pix(637, 475, img[19039], "edge_637");
        pix(0, 475,   img[18880], "edge_nowrap_0");

        // Degenerate box
        load_box(300, 50, 200, 150, 1'b0);
        frame_start();
        pix(250, 100, img[4062], "degen_250");
        pix(300, 100, img[4075], "degen_300");
        pix(200, 100, img[4050], "degen_200");

        // Accept in the commit cycle
        box_x0 = 10'd10; box_y0 = 10'd10; box_x1 = 10'd20; box_y1 = 10'd20;
        box_valid = 1'b1; vsync_in = 1'b0;
        step();
        box_valid = 1'b0; vsync_in = 1'b1;
        step();
        chk("same_cycle_pending", box_ready, 1'b0);
        pix(10, 15, img[482], "same_cycle_not_yet");
        frame_start();
        pix(10, 15, BOXC, "same_cycle_drawn");

        // Back-pressure: second request while pending is ignored
        load_box(30, 30, 40, 40, 1'b0);
        box_x0 = 10'd50; box_y0 = 10'd50; box_x1 = 10'd60; box_y1 = 10'd60; box_valid = 1'b1;
        step(); step(); step();
        chk("bp_ready_low", box_ready, 1'b0);
        box_valid = 1'b0;
        frame_start();
        pix(30, 35, BOXC,      "bp_first_drawn");
        pix(50, 55, img[2092], "bp_second_ignored");

        // Clear
        load_box(0, 0, 0, 0, 1'b1);
        pix(30, 35, BOXC, "clear_not_yet");
        frame_start();
        pix(30, 35, img[1287], "clear_done");

        // Reset mid-frame with a pending box
        load_box(30, 30, 40, 40, 1'b0);
        rst = 1'b1;
        step(); step();
        chk("midrst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("midrst_ready", box_ready, 1'b1);
        rst = 1'b0;
        frame_start();
        pix(30, 35, img[1287], "midrst_no_box");

        // Random traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            int bx;
            int by;
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) < 6) begin
                xpos = 10'($urandom_range(0, 100));
                ypos = 10'($urandom_range(0, 100));
            end else begin
                xpos = 10'($urandom_range(0, 799));
                ypos = 10'($urandom_range(0, 524));
            end
            de_in    = ($urandom_range(0, 9) != 0);
            hsync_in = ($urandom_range(0, 19) != 0);
            vsync_in = ($urandom_range(0, 59) != 0);
            box_valid = ($urandom_range(0, 19) == 0);
            box_clear = ($urandom_range(0, 4) == 0);
            bx = $urandom_range(0, 80);
            by = $urandom_range(0, 80);
            box_x0 = 10'(bx);
            box_y0 = 10'(by);
            box_x1 = 10'(bx + $urandom_range(0, 30) - 3);
            box_y1 = 10'(by + $urandom_range(0, 30) - 3);
            step();
        end
        rst = 1'b0; box_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
